// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and a sync-window decode helper
package vga_timing_pkg;
  localparam int CLK_DIV = 4;
  localparam int H_VISIBLE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
  function automatic logic in_window(input logic [9:0] x, input int lo, input int hi);
    return int'(x) >= lo && int'(x) <= hi;
  endfunction
endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// pixel_tick_gen: divide-by-CLK_DIV clock enable; pix_adv is the combinational advance, pix_tick its registered strobe
module pixel_tick_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset_button,
  output logic pix_adv,
  output logic pix_tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] div_cnt;
  assign pix_adv = div_cnt == LAST;
  always_ff @(posedge clk or posedge reset_button)
    if (reset_button) begin
      div_cnt <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_cnt <= pix_adv ? '0 : div_cnt + W'(1);
      pix_tick <= pix_adv;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters and registered decodes; define VGA_FRAME_COUNT_EN to add frame_count
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset_button,
  output logic       pix_tick,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       line_start,
  output logic       vblank_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);
  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_VISIBLE + H_FP;
  localparam int VSS = V_VISIBLE + V_FP;
  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  if (HT > 1024 || VT > 1024) begin : g_width_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  logic adv, h_wrap, vbs_n;
  logic [9:0] h_n, v_n;
  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset_button(reset_button),
    .pix_adv(adv),
    .pix_tick(pix_tick)
  );
  // decodes are taken from the next counter values so they land on the same edge as the counters
  always_comb begin
    h_wrap = adv && hCount == H_LAST;
    h_n = !adv ? hCount : h_wrap ? '0 : hCount + 10'd1;
    v_n = !h_wrap ? vCount : vCount == V_LAST ? '0 : vCount + 10'd1;
    vbs_n = adv && h_n == '0 && v_n == V_VIS;
  end
  always_ff @(posedge clk or posedge reset_button)
    if (reset_button) begin
      hCount <= H_LAST;
      vCount <= V_LAST;
      bright <= 1'b0;
      hSync <= 1'b1;
      vSync <= 1'b1;
      line_start <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      hCount <= h_n;
      vCount <= v_n;
      bright <= h_n < H_VIS && v_n < V_VIS;
      hSync <= !in_window(h_n, HSS, HSS + H_SYNC - 1);
      vSync <= !in_window(v_n, VSS, VSS + V_SYNC - 1);
      line_start <= adv && h_n == '0;
      vblank_start <= vbs_n;
    end
`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge reset_button)
    if (reset_button) frame_count <= '0;
    else if (vbs_n) frame_count <= frame_count + 16'd1;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboarded check of a default-timing DUT and a shrunken-timing DUT for frame-level behaviour
module tb_vga_timing_gen;
  typedef logic [25:0] vec_t;
  logic clk = 1'b0, reset_button = 1'b1;
  always #5 clk = ~clk;
  logic pix_tick_a, bright_a, hSync_a, vSync_a, line_start_a, vblank_start_a;
  logic pix_tick_b, bright_b, hSync_b, vSync_b, line_start_b, vblank_start_b;
  logic [9:0] hCount_a, vCount_a, hCount_b, vCount_b;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_a, frame_count_b, fc_exp;
`endif
  vga_timing_gen dut_a (
    .clk(clk), .reset_button(reset_button), .pix_tick(pix_tick_a), .hCount(hCount_a), .vCount(vCount_a),
    .bright(bright_a), .hSync(hSync_a), .vSync(vSync_a), .line_start(line_start_a), .vblank_start(vblank_start_a)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count_a)
`endif
  );
  vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut_b (
    .clk(clk), .reset_button(reset_button), .pix_tick(pix_tick_b), .hCount(hCount_b), .vCount(vCount_b),
    .bright(bright_b), .hSync(hSync_b), .vSync(vSync_b), .line_start(line_start_b), .vblank_start(vblank_start_b)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count_b)
`endif
  );
  int passed = 0, total = 0, cyc_n = 0;
  vec_t q_a[$], q_b[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  // position follows directly from the number of pixel ticks since reset release
  function automatic vec_t model(int c, int cd, int hv, int hfp, int hsy, int hbp, int vv, int vfp, int vsy, int vbp);
    int ht = hv + hfp + hsy + hbp;
    int vt = vv + vfp + vsy + vbp;
    int k = c / cd;
    int h = ht - 1, v = vt - 1;
    logic tick = c > 0 && c % cd == 0;
    if (k > 0) begin
      h = (k - 1) % ht;
      v = ((k - 1) / ht) % vt;
    end
    return {tick, 10'(h), 10'(v), h < hv && v < vv, !(h >= hv + hfp && h < hv + hfp + hsy),
            !(v >= vv + vfp && v < vv + vfp + vsy), tick && h == 0, tick && h == 0 && v == vv};
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!reset_button) cyc_n++;
      q_a.push_back(model(cyc_n, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      q_b.push_back(model(cyc_n, 2, 8, 2, 3, 3, 6, 1, 2, 2));
    end
  endtask
  always @(negedge clk) begin
    if (q_a.size() > 0)
      chk("scb_a", 32'({pix_tick_a, hCount_a, vCount_a, bright_a, hSync_a, vSync_a, line_start_a, vblank_start_a}), 32'(q_a.pop_front()));
    if (q_b.size() > 0)
      chk("scb_b", 32'({pix_tick_b, hCount_b, vCount_b, bright_b, hSync_b, vSync_b, line_start_b, vblank_start_b}), 32'(q_b.pop_front()));
  end
  int mcyc = 0, last_a = -1, last_b = -1, last_vbs = -1, br_b = 0, vs_b = 0, hs_lo_a = 0, ls_a = 0;
  always @(negedge clk) begin
    if (reset_button) begin
      last_a = -1; last_b = -1; last_vbs = -1; br_b = 0; vs_b = 0; hs_lo_a = 0; ls_a = 0;
`ifdef VGA_FRAME_COUNT_EN
      fc_exp = '0;
`endif
    end else begin
      mcyc++;
      if (pix_tick_a) begin
        if (last_a >= 0) chk("tick_gap_a", 32'(mcyc - last_a), 32'd4);
        last_a = mcyc;
        if (!hSync_a) hs_lo_a++;
        if (line_start_a) ls_a++;
      end
      if (pix_tick_b) begin
        if (last_b >= 0) chk("tick_gap_b", 32'(mcyc - last_b), 32'd2);
        last_b = mcyc;
        if (vblank_start_b) begin
          if (last_vbs >= 0) begin
            chk("vbs_period_b", 32'(mcyc - last_vbs), 32'd352);
            chk("bright_per_frame_b", 32'(br_b), 32'd48);
            chk("vsync_lo_per_frame_b", 32'(vs_b), 32'd32);
          end
          last_vbs = mcyc; br_b = 0; vs_b = 0;
`ifdef VGA_FRAME_COUNT_EN
          fc_exp = fc_exp + 16'd1;
`endif
        end
        if (bright_b) br_b++;
        if (!vSync_b) vs_b++;
      end
`ifdef VGA_FRAME_COUNT_EN
      chk("frame_count_b", 32'(frame_count_b), 32'(fc_exp));
`endif
    end
  end
  initial begin
    int guard;
    step(5);
    @(negedge clk); #1;
    chk("rst_h_a", 32'(hCount_a), 32'd799);
    chk("rst_v_a", 32'(vCount_a), 32'd524);
    chk("rst_dec_a", 32'({pix_tick_a, bright_a, hSync_a, vSync_a, line_start_a, vblank_start_a}), 32'b001100);
    #1 reset_button = 1'b0;
    step(4);
    @(negedge clk); #1;
    chk("first_tick_a", 32'({pix_tick_a, hCount_a, vCount_a, bright_a, line_start_a}), 32'({1'b1, 20'd0, 1'b1, 1'b1}));
    step(6436);
    @(negedge clk); #1;
    chk("hsync_lo_ticks_a", 32'(hs_lo_a), 32'd192);
    chk("line_starts_a", 32'(ls_a), 32'd3);
    chk("pos_after_2_lines_a", 32'({hCount_a, vCount_a}), 32'({10'd9, 10'd2}));
    guard = 0;
    while (!(hSync_b == 1'b0 && vSync_b == 1'b0) && guard < 1000) begin
      step(1);
      @(negedge clk); #1;
      guard++;
    end
    chk("sync_low_reached_b", 32'(guard < 1000), 32'd1);
    #1 reset_button = 1'b1;
    cyc_n = 0;
    #1;
    chk("async_rst_sync_b", 32'({hSync_b, vSync_b, line_start_b, vblank_start_b}), 32'b1100);
    chk("async_rst_pos_b", 32'({hCount_b, vCount_b}), 32'({10'd15, 10'd10}));
    chk("async_rst_pos_a", 32'({hCount_a, vCount_a}), 32'({10'd799, 10'd524}));
    step(3);
    @(negedge clk); #2 reset_button = 1'b0;
    step(2);
    @(negedge clk); #1;
    chk("restart_b", 32'({hCount_b, vCount_b, pix_tick_b, line_start_b}), 32'({20'd0, 1'b1, 1'b1}));
    step(800);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
